// File: rtl/fofb_recorder_readout.sv
// Readout sequencer: walks the recorder address from the first pretrigger sample and streams TX/RX words.
// Define FOFB_READOUT_HEADER_EN to prepend the acquisition timestamp as two header beats.
module fofb_recorder_readout #(
    parameter int  BUFFER_CAPACITY  = 32768,
    parameter int  CHANNEL_COUNT    = 24,
    localparam int ADDRESS_WIDTH    = $clog2(BUFFER_CAPACITY),
    localparam int CHAN_COUNT_WIDTH = $clog2(CHANNEL_COUNT + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        recFull,
    input  logic [ADDRESS_WIDTH-1:0]    recTriggerAddress,
    input  logic [CHAN_COUNT_WIDTH-1:0] channelCount,
    input  logic [ADDRESS_WIDTH:0]      pretriggerCount,
    input  logic [ADDRESS_WIDTH:0]      recordCount,
    input  logic [63:0]                 acqTimestamp,
    output logic [ADDRESS_WIDTH-1:0]    recAddress,
    output logic                        recAddressStrobe,
    input  logic [31:0]                 txData,
    input  logic [31:0]                 rxData,
    output logic [31:0]                 m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [1:0]                  m_axis_tuser,
    output logic [31:0]                 status
);
    localparam int MUL_WIDTH   = ADDRESS_WIDTH + CHAN_COUNT_WIDTH + 1;
    localparam int COUNT_WIDTH = ADDRESS_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, ADDR, WAIT, CAPT, SEND_TX, SEND_RX} state_t;

    state_t                      state, nextState;
    logic                        pending;
    logic [ADDRESS_WIDTH-1:0]    addrReg, trigLatched;
    logic [CHAN_COUNT_WIDTH-1:0] chLatched, chanLeft;
    logic [ADDRESS_WIDTH:0]      preLatched, recLatched;
    logic [COUNT_WIDTH-1:0]      wordsLeft, recordsLeft;
    logic [31:0]                 txHold, rxHold;
    logic                        done, error;
    logic [63:0]                 headerTimestamp;

    wire startAccepted = (state == IDLE) && !pending && start;
    wire startValid    = recFull && (channelCount != '0) && (recordCount != '0);
    wire rxDone        = (state == SEND_RX) && m_axis_tready && !abort;
    wire lastWord      = (wordsLeft == COUNT_WIDTH'(1));

    wire [MUL_WIDTH-1:0] wordProduct = MUL_WIDTH'(recLatched) * MUL_WIDTH'(chLatched);
    wire overCapacity = wordProduct > MUL_WIDTH'(BUFFER_CAPACITY);
    // Pretrigger offset may reach past address 0; the truncation wraps it to the buffer end.
    wire [ADDRESS_WIDTH-1:0] startAddress = ADDRESS_WIDTH'(MUL_WIDTH'(trigLatched)
                                            - MUL_WIDTH'(preLatched) * MUL_WIDTH'(chLatched));

`ifdef FOFB_READOUT_HEADER_EN
    localparam logic HEADER_EN = 1'b1;
    logic [63:0] timestampLatched;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timestampLatched <= '0;
        else if (startAccepted && startValid)
            timestampLatched <= acqTimestamp;
    end
    assign headerTimestamp = timestampLatched;
`else
    localparam logic HEADER_EN = 1'b0;
    logic unusedTimestamp;
    assign unusedTimestamp = ^acqTimestamp;
    assign headerTimestamp = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        nextState        = state;
        m_axis_tvalid    = 1'b0;
        m_axis_tdata     = '0;
        m_axis_tuser     = 2'd0;
        m_axis_tlast     = 1'b0;
        recAddressStrobe = 1'b0;
        case (state)
            IDLE:    if (pending && !abort) nextState = HEADER_EN ? HDR0 : ADDR;
            HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = headerTimestamp[63:32];
                m_axis_tuser  = 2'd2;
                if (m_axis_tready) nextState = HDR1;
            end
            HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = headerTimestamp[31:0];
                m_axis_tuser  = 2'd2;
                if (m_axis_tready) nextState = ADDR;
            end
            ADDR: begin
                recAddressStrobe = 1'b1;
                nextState        = WAIT;
            end
            WAIT:    nextState = CAPT;
            CAPT:    nextState = SEND_TX;
            SEND_TX: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = txHold;
                if (m_axis_tready) nextState = SEND_RX;
            end
            SEND_RX: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rxHold;
                m_axis_tuser  = 2'd1;
                m_axis_tlast  = lastWord;
                if (m_axis_tready) nextState = lastWord ? IDLE : ADDR;
            end
            default: nextState = IDLE;
        endcase
        if (abort && state != IDLE) nextState = IDLE;
    end

    // Start is accepted into a one-cycle pending slot while the start address is computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the holding registers are plain flops, not memory, so they reset with the control.
            pending     <= 1'b0;
            addrReg     <= '0;
            trigLatched <= '0;
            chLatched   <= '0;
            preLatched  <= '0;
            recLatched  <= '0;
            chanLeft    <= '0;
            wordsLeft   <= '0;
            recordsLeft <= '0;
            txHold      <= '0;
            rxHold      <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (startAccepted) begin
                if (!startValid) begin
                    error <= 1'b1;
                end else begin
                    pending     <= 1'b1;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    trigLatched <= recTriggerAddress;
                    chLatched   <= channelCount;
                    preLatched  <= pretriggerCount;
                    recLatched  <= recordCount;
                end
            end
            if (pending) begin
                pending <= 1'b0;
                if (!abort) begin
                    addrReg     <= startAddress;
                    wordsLeft   <= overCapacity ? COUNT_WIDTH'(BUFFER_CAPACITY) : COUNT_WIDTH'(wordProduct);
                    chanLeft    <= chLatched;
                    recordsLeft <= COUNT_WIDTH'(recLatched);
                    if (overCapacity) error <= 1'b1;
                end
            end
            if (state == CAPT) begin
                txHold <= txData;
                rxHold <= rxData;
            end
            if (rxDone) begin
                wordsLeft <= wordsLeft - COUNT_WIDTH'(1);
                addrReg   <= addrReg + ADDRESS_WIDTH'(1);
                if (chanLeft == CHAN_COUNT_WIDTH'(1)) begin
                    chanLeft    <= chLatched;
                    recordsLeft <= recordsLeft - COUNT_WIDTH'(1);
                end else begin
                    chanLeft <= chanLeft - CHAN_COUNT_WIDTH'(1);
                end
                if (lastWord) done <= 1'b1;
            end
        end
    end

    assign recAddress = addrReg;
    assign status     = {16'(recordsLeft), 13'd0, error, done, (state != IDLE) || pending};

endmodule

// File: tb/tb_fofb_recorder_readout.sv
// Scoreboard bench for fofb_recorder_readout: stimulus queues expected strobes and beats, monitors pop and compare.
module tb_fofb_recorder_readout;
    localparam int CAP = 32768;
`ifdef FOFB_READOUT_HEADER_EN
    localparam int FIRST_STROBE_LATENCY = 4;
`else
    localparam int FIRST_STROBE_LATENCY = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, recFull = 1'b1;
    logic [14:0] recTriggerAddress = '0;
    logic [4:0]  channelCount = '0;
    logic [15:0] pretriggerCount = '0, recordCount = '0;
    logic [63:0] acqTimestamp = 64'h0123_4567_89AB_CDEF;
    logic [14:0] recAddress;
    logic        recAddressStrobe;
    logic [31:0] txData = '0, rxData = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  m_axis_tuser;
    logic [31:0] status;

    fofb_recorder_readout dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .recFull(recFull),
        .recTriggerAddress(recTriggerAddress), .channelCount(channelCount),
        .pretriggerCount(pretriggerCount), .recordCount(recordCount), .acqTimestamp(acqTimestamp),
        .recAddress(recAddress), .recAddressStrobe(recAddressStrobe),
        .txData(txData), .rxData(rxData),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    beat_t       beatQ[$];
    logic [14:0] addrQ[$];
    int testsRun = 0, testsFailed = 0;
    int cycleCount = 0, startCycle = 0, lastStrobe = 0, hsCount = 0;
    bit latencyArmed = 0, gapCheck = 0, strobeSeen = 0, abortWindow = 0;

    function automatic logic [31:0] txWord(input logic [14:0] a);
        return 32'hA000_0000 | 32'(a);
    endfunction
    function automatic logic [31:0] rxWord(input logic [14:0] a);
        return 32'h5000_0000 | (32'(a) << 8);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] actual);
        testsRun++;
        testsFailed++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, actual);
    endtask

    function automatic void pushBeat(input logic [31:0] d, input logic [1:0] u, input logic l);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        beatQ.push_back(b);
    endfunction

    function automatic void pushHeader();
`ifdef FOFB_READOUT_HEADER_EN
        pushBeat(32'h0123_4567, 2'd2, 1'b0);
        pushBeat(32'h89AB_CDEF, 2'd2, 1'b0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter and recorder model: data is valid only in the second cycle after the strobe.
    initial forever begin
        @(posedge clk);
        cycleCount++;
    end

    initial begin
        logic [14:0] stage1, stage2;
        bit v1, v2;
        v1 = 0; v2 = 0; stage1 = '0; stage2 = '0;
        forever begin
            @(negedge clk);
            if (v2) begin
                txData = txWord(stage2);
                rxData = rxWord(stage2);
            end else begin
                txData = 32'hDEAD_BEEF;
                rxData = 32'hDEAD_BEEF;
            end
            v2 = v1; stage2 = stage1;
            v1 = recAddressStrobe; stage1 = recAddress;
        end
    end

    // Strobe monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && recAddressStrobe) begin
            if (addrQ.size() == 0) unexpected("extra strobe", 64'(recAddress));
            else check("strobe address", 64'(recAddress), 64'(addrQ.pop_front()));
            if (latencyArmed) begin
                check("start to strobe latency", 64'(cycleCount - startCycle), 64'(FIRST_STROBE_LATENCY));
                latencyArmed = 0;
            end else if (gapCheck && strobeSeen) begin
                check("strobe interval", 64'(cycleCount - lastStrobe), 64'd5);
            end
            strobeSeen = 1;
            lastStrobe = cycleCount;
        end
    end

    // Stream monitor: pops on handshake, checks stability while stalled
    initial begin
        logic [31:0] sData;
        logic [1:0]  sUser;
        logic        sLast;
        bit stallActive;
        beat_t e;
        stallActive = 0; sData = '0; sUser = '0; sLast = 0;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                hsCount++;
                if (beatQ.size() == 0) begin
                    unexpected("extra beat", 64'(m_axis_tdata));
                end else begin
                    e = beatQ.pop_front();
                    check("beat data", 64'(m_axis_tdata), 64'(e.data));
                    check("beat tuser", 64'(m_axis_tuser), 64'(e.user));
                    check("beat tlast", 64'(m_axis_tlast), 64'(e.last));
                end
                stallActive = 0;
            end else if (m_axis_tvalid) begin
                if (stallActive) begin
                    check("stalled tdata stable", 64'(m_axis_tdata), 64'(sData));
                    check("stalled tuser stable", 64'(m_axis_tuser), 64'(sUser));
                    check("stalled tlast stable", 64'(m_axis_tlast), 64'(sLast));
                end
                stallActive = 1;
                sData = m_axis_tdata; sUser = m_axis_tuser; sLast = m_axis_tlast;
            end else begin
                if (stallActive && !abortWindow) unexpected("tvalid withdrawn", 64'(m_axis_tdata));
                stallActive = 0;
            end
        end
    end

    // Queue the full expected response, then pulse start with the latency check armed.
    task automatic runReadout(input int trig, input int ch, input int pre, input int rc);
        int s, words;
        logic [14:0] a;
        recTriggerAddress = 15'(trig);
        channelCount = 5'(ch);
        pretriggerCount = 16'(pre);
        recordCount = 16'(rc);
        s = trig - pre * ch;
        s = ((s % CAP) + CAP) % CAP;
        words = (rc * ch > CAP) ? CAP : rc * ch;
        pushHeader();
        for (int i = 0; i < words; i++) begin
            a = 15'((s + i) % CAP);
            addrQ.push_back(a);
            pushBeat(txWord(a), 2'd0, 1'b0);
            pushBeat(rxWord(a), 2'd1, i == words - 1);
        end
        strobeSeen = 0;
        startCycle = cycleCount;
        latencyArmed = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((status[0] || beatQ.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(n < 3000), 64'd1);
    endtask

    initial begin
        int n, hs0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset tdata/tuser/tlast", {m_axis_tdata, 29'd0, m_axis_tuser, m_axis_tlast}, 64'd0);
        check("reset address/strobe", {48'd0, recAddress, recAddressStrobe}, 64'd0);
        check("reset status", 64'(status), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic readout at full rate
        gapCheck = 1;
        runReadout(100, 4, 2, 3);
        waitIdle("basic completes");
        check("basic status", 64'(status), 64'h2);

        // Start address wraps below zero, addresses roll over 32767 -> 0
        runReadout(2, 4, 1, 1);
        waitIdle("wrap completes");
        check("wrap status", 64'(status), 64'h2);

        // Backpressure on the third beat
        gapCheck = 0;
        hs0 = hsCount;
        runReadout(100, 4, 2, 3);
        n = 0;
        while (hsCount < hs0 + 2 && n < 200) begin
            tick();
            n++;
        end
        check("backpressure reached beat 3", 64'(n < 200), 64'd1);
        m_axis_tready = 1'b0;
        repeat (10) tick();
        m_axis_tready = 1'b1;
        waitIdle("backpressure completes");
        check("backpressure status", 64'(status), 64'h2);

        // Start without a full recorder: error only, nothing emitted
        recFull = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("no-full tvalid low", 64'(m_axis_tvalid), 64'd0);
            tick();
        end
        check("no-full status", 64'(status), 64'h6);
        recFull = 1'b1;

        // Over-capacity word count: clamped with error, then aborted
        recTriggerAddress = '0;
        channelCount = 5'd4;
        pretriggerCount = '0;
        recordCount = 16'd9000;
`ifdef FOFB_READOUT_HEADER_EN
        pushBeat(32'h0123_4567, 2'd2, 1'b0);
`else
        addrQ.push_back(15'd0);
`endif
        strobeSeen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("clamp status busy+error", 64'(status), {32'd0, 16'd9000, 16'h0005});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("clamp abort status", 64'(status), {32'd0, 16'd9000, 16'h0004});
        check("clamp abort tvalid", 64'(m_axis_tvalid), 64'd0);

        // Abort while a TX word is presented, then a clean readout
        recTriggerAddress = 15'd100;
        pretriggerCount = 16'd2;
        recordCount = 16'd3;
        pushHeader();
        addrQ.push_back(15'd92);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(m_axis_tvalid && m_axis_tuser == 2'd0) && n < 50) begin
            tick();
            n++;
        end
        check("abort reached SEND_TX", 64'(n < 50), 64'd1);
        m_axis_tready = 1'b0;
        abort = 1'b1;
        abortWindow = 1;
        tick();
        abort = 1'b0;
        check("abort tvalid", 64'(m_axis_tvalid), 64'd0);
        check("abort busy/done", 64'(status[1:0]), 64'd0);
        tick();
        abortWindow = 0;
        m_axis_tready = 1'b1;
        gapCheck = 1;
        runReadout(100, 4, 2, 3);
        waitIdle("post-abort completes");
        check("post-abort status", 64'(status), 64'h2);

        // Asynchronous reset in the middle of a readout
        gapCheck = 0;
        hs0 = hsCount;
        runReadout(100, 4, 2, 3);
        n = 0;
        while (hsCount < hs0 + 3 && n < 200) begin
            tick();
            n++;
        end
        check("reset point reached", 64'(n < 200), 64'd1);
        abortWindow = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid reset tdata/tuser/tlast", {m_axis_tdata, 29'd0, m_axis_tuser, m_axis_tlast}, 64'd0);
        check("mid reset address/strobe", {48'd0, recAddress, recAddressStrobe}, 64'd0);
        check("mid reset status", 64'(status), 64'd0);
        addrQ.delete();
        beatQ.delete();
        latencyArmed = 0;
        tick();
        rst_n = 1'b1;
        tick();
        abortWindow = 0;

        check("strobe queue drained", 64'(addrQ.size()), 64'd0);
        check("beat queue drained", 64'(beatQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fofb_recorder_readout.md
# fofb_recorder_readout

Readout sequencer for the fast orbit feedback waveform recorder. After an acquisition completes, it walks the recorder's readout address through the captured record, starting at the first pretrigger sample and wrapping modulo the buffer size. It streams the interleaved TX/RX words out on an AXI-Stream master so the DMA path can drain the buffer without CPU address writes. It sits between the recorder's readout port (address strobe plus registered data) and the stream fabric.

## Interface
- `BUFFER_CAPACITY`, 32768: recorder depth in words; must be a power of two.
- `CHANNEL_COUNT`, 24: maximum channels per record.
- `ADDRESS_WIDTH`, local: $clog2(BUFFER_CAPACITY).
- `CHAN_COUNT_WIDTH`, local: $clog2(CHANNEL_COUNT+1).

Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, shared with the recorder.
- `rst_n`  in  1  asynchronous active-low reset.

Control and status:
- `start`  in  1  single-cycle pulse; begins a readout.
- `abort`  in  1  single-cycle pulse; returns to idle.
- `recFull`  in  1  recorder full flag.
- `recTriggerAddress`  in  ADDRESS_WIDTH  base address of the trigger record.
- `channelCount`  in  CHAN_COUNT_WIDTH  words per record.
- `pretriggerCount`  in  ADDRESS_WIDTH+1  records before the trigger record.
- `recordCount`  in  ADDRESS_WIDTH+1  total records to send.
- `acqTimestamp`  in  64  acquisition timestamp.
- `recAddress`  out  ADDRESS_WIDTH  readout address to the recorder.
- `recAddressStrobe`  out  1  load strobe for the readout address.

Recorder data and stream output:
- `txData`, `rxData`  in  32  recorder readout data.
- `m_axis_tdata`  out  32  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last word of the readout.
- `m_axis_tuser`  out  2  word type: 0 = TX, 1 = RX, 2 = header.
- `status`  out  32  bit0 busy, bit1 done (sticky), bit2 error (sticky); bits [31:16] records remaining.

## Operation
- States: `IDLE`, `HDR0`, `HDR1`, `ADDR`, `WAIT`, `CAPT`, `SEND_TX`, `SEND_RX`.
- `IDLE` + `start`:
  - If `!recFull`, or `channelCount == 0`, or `recordCount == 0`: set error and stay in `IDLE`.
  - Otherwise:
    - Clear done and error.
    - Start address = `recTriggerAddress - pretriggerCount*channelCount`, truncated to ADDRESS_WIDTH (modular wrap).
    - Word count = `recordCount*channelCount`. If it exceeds BUFFER_CAPACITY, clamp it to BUFFER_CAPACITY and set error.
    - Latch all inputs.
    - Go to `HDR0` if the header is enabled, else `ADDR`.
- `ADDR`: drive `recAddress` and pulse `recAddressStrobe` for one cycle, then go to `WAIT`.
- `WAIT`: one cycle for the recorder's address register to load.
- `CAPT`: register `txData` and `rxData` into holding registers, then go to `SEND_TX`.
- `SEND_TX`: present the TX word with tuser=0; on handshake go to `SEND_RX`.
- `SEND_RX`: present the RX word with tuser=1. On handshake:
  - Decrement the word count.
  - Increment the address; ADDRESS_WIDTH overflow wraps to 0.
  - If the count is now 0, assert `tlast` on this RX word, set done, and go to `IDLE`.
  - Otherwise go to `ADDR`.
- The records-remaining field decrements after every `channelCount` words.
- `abort` in any non-idle state:
  - Go to `IDLE` next cycle and drop `tvalid` immediately, even mid-beat (the downstream DMA resets too).
  - Done is not set.
- `start` while busy: ignored.

## Timing
- Reset values:
  - State `IDLE`; `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser` = 0; `m_axis_tdata` = 0.
  - `recAddress` = 0; `recAddressStrobe` = 0; `status` = 0.
- From `start` to the first `recAddressStrobe` (header disabled): 2 cycles. The cycle after `start` computes the start address; the strobe is asserted in the next.
- Recorder read latency is 2 cycles from strobe to valid `txData`/`rxData`; `CAPT` samples exactly 2 cycles after `ADDR`.
- Throughput with `tready` held high: 5 cycles per address (ADDR, WAIT, CAPT, TX, RX).
- `tdata`, `tuser` and `tlast` are stable while `tvalid && !tready`.
- `tvalid` is never withdrawn except on `abort` or reset.
- Reset asserted mid-readout returns all outputs to their reset values asynchronously.
- Multiplications are unsigned, computed at ADDRESS_WIDTH+CHAN_COUNT_WIDTH+1 bits before compare/truncate.

## Configuration
- `FOFB_READOUT_HEADER_EN` defined:
  - `HDR0` emits `acqTimestamp[63:32]` and `HDR1` emits `acqTimestamp[31:0]`, both with tuser=2, before the first address.
  - The timestamp is latched at `start`.
- Undefined: the header states are omitted and the stream begins with the first TX word.

## Test plan
- Basic, capacity 32768, no header:
  - Stimulus: channelCount=4, pretriggerCount=2, recTriggerAddress=100, recordCount=3, tready=1.
  - Response: 12 strobes with addresses 92..103, 24 beats alternating tuser 0/1, `tlast` only on the 24th, done=1, first strobe 2 cycles after `start`.
- Wrap-around:
  - Stimulus: recTriggerAddress=2, channelCount=4, pretriggerCount=1.
  - Response: start address 32766; the address sequence 32766, 32767, 0, 1, … continues with no gap.
- Backpressure:
  - Stimulus: hold tready=0 for 10 cycles during the 3rd beat.
  - Response: tdata/tuser stable throughout, no extra strobes, word order preserved.
- Error cases:
  - `start` with recFull=0 → error=1, no strobe, tvalid stays 0.
  - recordCount=9000 with channelCount=4 → word count clamped to 32768 and error=1.
- Abort: `abort` during `SEND_TX` → tvalid=0 next cycle, state `IDLE`, done=0; a following `start` reads out correctly.
- Header (macro defined): acqTimestamp=0x0123456789ABCDEF → first two beats 0x01234567, 0x89ABCDEF with tuser=2, then data as in the basic case.
